// File: rtl/clock_meter.sv
// Measures the period (and, with CLOCK_METER_DUTY_EN defined, the high phase) of
// clock_sense in cycles of clock, one measurement per start request.
module clock_meter #(
    parameter logic [31:0] TIMEOUT = 32'd200000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clock_sense,
    input  logic        start,
    output logic        busy,
    output logic        valid,
    output logic        timeout,
    output logic [31:0] period,
    output logic [31:0] high_time
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE
    } state_t;

    state_t      state_reg;
    logic        sync1_reg;
    logic        sync2_reg;
    logic        hist_reg;
    logic [31:0] counter_reg;
    logic        busy_reg;
    logic        valid_reg;
    logic        timeout_reg;
    logic [31:0] period_reg;
    logic        rise;

    // Two flops to resolve metastability, a third to remember the previous level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            hist_reg  <= 1'b0;
        end else begin
            sync1_reg <= clock_sense;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    assign rise = sync2_reg & ~hist_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            counter_reg <= 32'd0;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            period_reg  <= 32'd0;
        end else begin
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= WAIT_EDGE;
                        counter_reg <= 32'd0;
                        busy_reg    <= 1'b1;
                    end
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        state_reg   <= MEASURE;
                        counter_reg <= 32'd1;
                    end else if (counter_reg == TIMEOUT) begin
                        state_reg   <= IDLE;
                        counter_reg <= 32'd0;
                        busy_reg    <= 1'b0;
                        timeout_reg <= 1'b1;
                    end else begin
                        counter_reg <= counter_reg + 32'd1;
                    end
                end
                MEASURE: begin
                    // Counter was 1 the cycle after the opening rise, so it now holds t1-t0.
                    if (rise) begin
                        state_reg   <= IDLE;
                        counter_reg <= 32'd0;
                        busy_reg    <= 1'b0;
                        valid_reg   <= 1'b1;
                        period_reg  <= counter_reg;
                    end else if (counter_reg == TIMEOUT) begin
                        state_reg   <= IDLE;
                        counter_reg <= 32'd0;
                        busy_reg    <= 1'b0;
                        timeout_reg <= 1'b1;
                    end else begin
                        counter_reg <= counter_reg + 32'd1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    counter_reg <= 32'd0;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign valid   = valid_reg;
    assign timeout = timeout_reg;
    assign period  = period_reg;

`ifdef CLOCK_METER_DUTY_EN
    logic        fall;
    logic        fall_seen_reg;
    logic [31:0] high_cap_reg;
    logic [31:0] high_time_reg;

    assign fall = ~sync2_reg & hist_reg;

    // The fall is staged in high_cap_reg and only published with the closing rise,
    // so an aborted measurement leaves high_time untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fall_seen_reg <= 1'b0;
            high_cap_reg  <= 32'd0;
            high_time_reg <= 32'd0;
        end else if (state_reg == MEASURE) begin
            if (rise) begin
                high_time_reg <= fall_seen_reg ? high_cap_reg : 32'd0;
            end else if (fall && !fall_seen_reg) begin
                fall_seen_reg <= 1'b1;
                high_cap_reg  <= counter_reg;
            end
        end else begin
            fall_seen_reg <= 1'b0;
        end
    end

    assign high_time = high_time_reg;
`else
    assign high_time = 32'd0;
`endif

endmodule

// File: doc/clock_meter.md
CLOCK_METER -- requirements
Module: clock_meter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32'd200000000, meaning the maximum cycle count before a measurement aborts.
REQ-002 SHALL have port clock, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port clock_sense, input, 1 bit: the clock under measurement, asynchronous to clock.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin one measurement.
REQ-006 SHALL have port busy, output, 1 bit: high while a measurement is in progress.
REQ-007 SHALL have port valid, output, 1 bit: a one-cycle pulse when period/high_time are updated.
REQ-008 SHALL have port timeout, output, 1 bit: a one-cycle pulse when a measurement aborts.
REQ-009 SHALL have port period, output, 32 bits: the last measured period in clock cycles.
REQ-010 SHALL have port high_time, output, 32 bits: the last measured high phase in clock cycles.

Function
REQ-011 SHALL pass clock_sense through a 2-flop synchronizer plus one history flop; rise/fall = single-cycle pulses on synchronized 0->1 / 1->0.
REQ-012 SHALL implement FSM states IDLE, WAIT_EDGE, MEASURE.
REQ-013 IDLE: start=1 -> WAIT_EDGE, counter<=0, busy=1 from next cycle; edges in IDLE are ignored, including an edge coincident with start.
REQ-014 WAIT_EDGE: on rise -> MEASURE, counter<=1; otherwise counter increments.
REQ-015 MEASURE: counter increments each cycle; on rise -> period<=counter, valid pulses next cycle, -> IDLE.
REQ-016 Period SHALL equal t1-t0 for consecutive rise pulses at cycles t0, t1 (synchronizer latency cancels).
REQ-017 MEASURE: on the first fall, high_time<=counter (= tf-t0); later falls are ignored.
REQ-018 If no fall occurs before the closing rise, high_time SHALL be written 0.
REQ-019 In WAIT_EDGE or MEASURE, counter==TIMEOUT without the required rise SHALL pulse timeout next cycle, -> IDLE, and leave period/high_time unchanged.
REQ-020 Counter SHALL be 32 bits, never wrap (bounded by TIMEOUT), TIMEOUT>=2.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 period/high_time SHALL hold between valid pulses.
REQ-023 valid and timeout SHALL be mutually exclusive.
REQ-024 busy SHALL drop in the cycle valid or timeout is high.

Reset
REQ-025 reset_n=0 SHALL asynchronously force: IDLE, counter=0, synchronizer flops=0, busy=0, valid=0, timeout=0, period=0, high_time=0.
REQ-026 Reset mid-measurement SHALL abort with no valid/timeout pulse; a new start is required afterwards.

Configuration
REQ-027 CLOCK_METER_DUTY_EN defined: high_time measured per REQ-017/018.
REQ-028 CLOCK_METER_DUTY_EN undefined: fall detection and high_time register removed, high_time tied to 32'd0; period behaviour is identical.

Verification
REQ-029 clock_sense = clock/10, high 5 cycles, start pulse -> valid within 25 cycles, period=10, high_time=5 (0 without the macro).
REQ-030 clock_sense = clock/7, high 3 cycles, two back-to-back measurements -> period=7, high_time=3 both times; the second start during busy is ignored.
REQ-031 TIMEOUT=64, clock_sense stuck 0, start -> timeout pulse 65 cycles after WAIT_EDGE entry, period/high_time unchanged, busy=0.
REQ-032 TIMEOUT=64, clock_sense one rise then stuck 1 -> timeout pulse, no valid.
REQ-033 reset_n asserted mid-MEASURE with a clock/10 input -> all outputs 0 immediately; no pulse after release; a fresh start yields period=10.
